// File: rtl/ps2_pkg.sv
// Shared constants and frame-FSM encoding for the PS/2 keyboard input stage.
package ps2_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] PS2_BREAK = 8'hF0;
  localparam logic [BYTE_W-1:0] PS2_EXT   = 8'hE0;

  localparam logic [BYTE_W-1:0] KEY_LEFT  = 8'h6B;
  localparam logic [BYTE_W-1:0] KEY_RIGHT = 8'h74;
  localparam logic [BYTE_W-1:0] KEY_UP    = 8'h75;
  localparam logic [BYTE_W-1:0] KEY_DOWN  = 8'h72;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver: synchronise, filter the
// clock, deframe on its falling edge and abort frames that stall.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic              byte_valid,
  output logic [BYTE_W-1:0] byte_data,
  output logic              frame_err
);

  localparam int unsigned FW = 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic              clk_s1_q, clk_s2_q, data_s1_q, data_s2_q;
  logic              filt_clk_q, filt_clk_d;
  logic [FW-1:0]     filt_cnt_q, filt_cnt_d;
  logic              fall_q, fall_d;
  frame_state_e      state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              parity_q, parity_d;
  logic [TW-1:0]     idle_cnt_q, idle_cnt_d;
  logic              byte_valid_q, byte_valid_d;
  logic [BYTE_W-1:0] byte_data_q, byte_data_d;
  logic              frame_err_q, frame_err_d;

  // Idle PS/2 lines are high, so the synchronisers reset to 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      clk_s1_q  <= ps2_clk;
      clk_s2_q  <= clk_s1_q;
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  always_comb begin
    filt_clk_d = filt_clk_q;
    filt_cnt_d = '0;
    if (clk_s2_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_s2_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall_d = filt_clk_q & ~filt_clk_d;
  end

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    idle_cnt_d   = idle_cnt_q;
    byte_valid_d = 1'b0;
    byte_data_d  = byte_data_q;
    frame_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        idle_cnt_d = '0;
        if (fall_q && !data_s2_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (fall_q) begin
          shift_d   = {data_s2_q, shift_q[BYTE_W-1:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall_q) begin
          parity_d = data_s2_q;
          state_d  = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall_q) begin
          if (data_s2_q && (^{shift_q, parity_q})) begin
            byte_valid_d = 1'b1;
            byte_data_d  = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A strobe in the expiry cycle wins over the timeout.
    if (state_q != ST_IDLE) begin
      if (fall_q) begin
        idle_cnt_d = '0;
      end else if (idle_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d     = ST_IDLE;
        idle_cnt_d  = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_clk_q   <= 1'b1;
      filt_cnt_q   <= '0;
      fall_q       <= 1'b0;
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      idle_cnt_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_data_q  <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      filt_clk_q   <= filt_clk_d;
      filt_cnt_q   <= filt_cnt_d;
      fall_q       <= fall_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_valid_q <= byte_valid_d;
      byte_data_q  <= byte_data_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign byte_valid = byte_valid_q;
  assign byte_data  = byte_data_q;
  assign frame_err  = frame_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 make/break decoder: tracks the currently held key for the game logic;
// the last key pressed wins and key_code reads 00 when nothing is held.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  output logic [BYTE_W-1:0] key_code,
  output logic              key_ext,
  output logic              key_valid,
  output logic              frame_err
);

  logic              rx_valid;
  logic [BYTE_W-1:0] rx_byte;
  logic              rx_err;

  logic [BYTE_W-1:0] key_code_q, key_code_d;
  logic              key_ext_q, key_ext_d;
  logic              key_valid_q, key_valid_d;
  logic              brk_q, brk_d;
  logic              ext_q, ext_d;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(rx_valid),
    .byte_data (rx_byte),
    .frame_err (rx_err)
  );

  always_comb begin
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_valid_d = 1'b0;
    brk_d       = brk_q;
    ext_d       = ext_q;

    if (rx_err) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PS2_BREAK) begin
        brk_d = 1'b1;
      end else if (brk_q) begin
        // Releasing a key that is not the held one leaves the held key alone.
        if ((rx_byte == key_code_q) && (ext_q == key_ext_q)) begin
          key_code_d = '0;
          key_ext_d  = 1'b0;
        end
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        key_code_d  = rx_byte;
        key_ext_d   = ext_q;
        key_valid_d = 1'b1;
        ext_d       = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_code_q  <= '0;
      key_ext_q   <= 1'b0;
      key_valid_q <= 1'b0;
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
    end else begin
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_valid_q <= key_valid_d;
      brk_q       <= brk_d;
      ext_q       <= ext_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_valid = key_valid_q;
  assign frame_err = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: sends PS/2 frames at a scaled bit rate
// and checks held-key tracking, pulses, error handling and reset.
module tb_ps2_key_decoder;
  import ps2_pkg::*;

  localparam int unsigned FL      = 8;
  localparam int unsigned TIMEOUT = 1000;
  localparam int unsigned HALF    = 40;

  logic       clk, rst, ps2_clk, ps2_data;
  logic [7:0] key_code;
  logic       key_ext, key_valid, frame_err;

  int n_assert = 0;
  int n_fail   = 0;
  int kv_cnt = 0, fe_cnt = 0, kv_long = 0, fe_long = 0;
  logic kv_prev = 1'b0, fe_prev = 1'b0;
  int kv0, fe0;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .key_code(key_code), .key_ext(key_ext), .key_valid(key_valid), .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and width watchdogs.
  always @(posedge clk) begin
    kv_prev <= key_valid;
    fe_prev <= frame_err;
    if (key_valid) kv_cnt <= kv_cnt + 1;
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (key_valid && kv_prev) kv_long <= kv_long + 1;
    if (frame_err && fe_prev) fe_long <= fe_long + 1;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input bit glitch, input bit chk_lat, input logic [7:0] prev);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = fr[i];
      if (glitch && i == 4) begin
        repeat (HALF / 2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - HALF / 2 - 3) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (chk_lat && i == 10) begin
        repeat (FL + 3) @(posedge clk);
        #1 chk("latency_before", key_code, prev);
        @(posedge clk);
        #1 chk("latency_after", key_code, b);
        repeat (HALF - FL - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    logic [8:0] fr;
    fr = {b, 1'b0};
    for (int i = 0; i <= nbits; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_key_code", key_code, 8'h00);
    chk("rst_key_ext", {7'd0, key_ext}, 8'h00);
    chk("rst_key_valid", {7'd0, key_valid}, 8'h00);
    chk("rst_frame_err", {7'd0, frame_err}, 8'h00);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single make code with latency check.
    kv0 = kv_cnt;
    send_frame(KEY_LEFT, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("left_ext", {7'd0, key_ext}, 8'h00);
    chk("left_kv_pulses", 8'(kv_cnt - kv0), 8'd1);

    // Extended make then extended break.
    kv0 = kv_cnt;
    send(PS2_EXT); send(KEY_UP);
    chk("ext_up_code", key_code, 8'h75);
    chk("ext_up_ext", {7'd0, key_ext}, 8'h01);
    send(PS2_EXT); send(PS2_BREAK); send(KEY_UP);
    chk("ext_brk_code", key_code, 8'h00);
    chk("ext_brk_ext", {7'd0, key_ext}, 8'h00);
    chk("ext_kv_pulses", 8'(kv_cnt - kv0), 8'd1);

    // Last key pressed wins; releasing the other key is ignored.
    send(KEY_RIGHT); send(KEY_DOWN);
    chk("two_keys_code", key_code, 8'h72);
    send(PS2_BREAK); send(KEY_RIGHT);
    chk("stale_break_code", key_code, 8'h72);
    send(PS2_BREAK); send(KEY_DOWN);
    chk("held_break_code", key_code, 8'h00);

    // Parity and stop-bit errors.
    send(KEY_RIGHT);
    fe0 = fe_cnt;
    send_frame(KEY_LEFT, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("par_err_pulses", 8'(fe_cnt - fe0), 8'd1);
    chk("par_err_code", key_code, 8'h74);
    send_frame(KEY_LEFT, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    chk("stop_err_pulses", 8'(fe_cnt - fe0), 8'd2);
    chk("stop_err_code", key_code, 8'h74);

    // An error after F0 drops the break flag, so the next byte is a make.
    kv0 = kv_cnt;
    send(PS2_BREAK);
    send_frame(KEY_RIGHT, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    send(KEY_RIGHT);
    chk("err_clr_brk_code", key_code, 8'h74);
    chk("err_clr_brk_kv", 8'(kv_cnt - kv0), 8'd1);

    // Short clock glitch mid-frame is filtered out.
    kv0 = kv_cnt; fe0 = fe_cnt;
    send_frame(KEY_DOWN, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    chk("glitch_code", key_code, 8'h72);
    chk("glitch_kv", 8'(kv_cnt - kv0), 8'd1);
    chk("glitch_fe", 8'(fe_cnt - fe0), 8'd0);

    // Stalled frame times out, then a full frame decodes.
    fe0 = fe_cnt;
    send_partial(KEY_UP, 5);
    repeat (TIMEOUT + 100) @(negedge clk);
    chk("timeout_fe", 8'(fe_cnt - fe0), 8'd1);
    chk("timeout_code", key_code, 8'h72);
    send(KEY_LEFT);
    chk("after_timeout_code", key_code, 8'h6B);

    // Reset mid-frame clears immediately; receiver restarts cleanly.
    send_partial(KEY_RIGHT, 4);
    repeat (HALF / 2) @(negedge clk);
    rst = 1'b1;
    #1 chk("midframe_rst_code", key_code, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    send(KEY_UP);
    chk("post_rst_code", key_code, 8'h75);
    chk("post_rst_ext", {7'd0, key_ext}, 8'h00);

    chk("kv_width", 8'(kv_long), 8'd0);
    chk("fe_width", 8'(fe_long), 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
